// File: rtl/ex_md_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_md_pkg
// Brief    : Shared encodings for the Sirius execute stage (aluop, alusel,
//            divider FSM state) and common reset/write constants.
// Revision : 1.0 - initial release
// ============================================================================
package ex_md_pkg;

    localparam logic c_rst_enable    = 1'b1;
    localparam logic c_write_disable = 1'b0;

    // Result class
    localparam logic [2:0] c_res_nop   = 3'b000;
    localparam logic [2:0] c_res_logic = 3'b001;
    localparam logic [2:0] c_res_shift = 3'b010;
    localparam logic [2:0] c_res_move  = 3'b011;
    localparam logic [2:0] c_res_arith = 3'b100;

    // Operation codes
    localparam logic [7:0] c_exe_nop   = 8'b0000_0000;
    localparam logic [7:0] c_exe_or    = 8'b0010_0101;
    localparam logic [7:0] c_exe_and   = 8'b0010_0100;
    localparam logic [7:0] c_exe_xor   = 8'b0010_0110;
    localparam logic [7:0] c_exe_nor   = 8'b0010_0111;
    localparam logic [7:0] c_exe_sll   = 8'b0111_1100;
    localparam logic [7:0] c_exe_srl   = 8'b0000_0010;
    localparam logic [7:0] c_exe_sra   = 8'b0000_0011;
    localparam logic [7:0] c_exe_ror   = 8'b0000_0100;
    localparam logic [7:0] c_exe_add   = 8'b0010_0000;
    localparam logic [7:0] c_exe_addu  = 8'b0010_0001;
    localparam logic [7:0] c_exe_sub   = 8'b0010_0010;
    localparam logic [7:0] c_exe_subu  = 8'b0010_0011;
    localparam logic [7:0] c_exe_slt   = 8'b0010_1010;
    localparam logic [7:0] c_exe_sltu  = 8'b0010_1011;
    localparam logic [7:0] c_exe_mult  = 8'b0001_1000;
    localparam logic [7:0] c_exe_multu = 8'b0001_1001;
    localparam logic [7:0] c_exe_div   = 8'b0001_1010;
    localparam logic [7:0] c_exe_divu  = 8'b0001_1011;
    localparam logic [7:0] c_exe_mfhi  = 8'b0001_0000;
    localparam logic [7:0] c_exe_mthi  = 8'b0001_0001;
    localparam logic [7:0] c_exe_mflo  = 8'b0001_0010;
    localparam logic [7:0] c_exe_mtlo  = 8'b0001_0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DIVZ = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_md_div_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative radix-2 restoring divider on operand magnitudes, with
//            sign fix-up and a 2-cycle divide-by-zero path.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
    import ex_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int c_cw = $clog2(WIDTH);
    // WIDTH is a power of two, so WIDTH-1 is all ones in the counter width
    localparam logic [c_cw-1:0] c_cnt_last = '1;

    div_state_e       r_state;
    div_state_e       w_next;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift_in;
    logic [WIDTH:0]   w_trial;

    assign w_dvd_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign w_shift_in = {r_rem, r_quot[WIDTH-1]};
    assign w_trial    = w_shift_in - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (divisor == '0) ? S_DIVZ : S_BUSY;
            S_BUSY:  if (r_cnt == c_cnt_last) w_next = S_DONE;
            S_DIVZ:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            // Quotient register doubles as the dividend shifter
                            r_quot  <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                            r_rem   <= '0;
                            r_neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg_r <= signed_op & dividend[WIDTH-1];
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_trial[WIDTH]) begin
                        r_rem  <= w_trial[WIDTH-1:0];
                        r_quot <= {r_quot[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_shift_in[WIDTH-1:0];
                        r_quot <= {r_quot[WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (r_state == S_DONE);
    assign quotient  = r_neg_q ? -r_quot : r_quot;
    assign remainder = r_neg_r ? -r_rem  : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_md.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_md
// Brief    : Sirius execute stage: logic/shift/arith ALU, single-cycle
//            multiplier, iterative divider and the HI/LO register pair.
// Revision : 1.0 - initial release
// ============================================================================
module ex_md
    import ex_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [7:0]         aluop_i,
    input  logic [2:0]         alusel_i,
    input  logic [WIDTH-1:0]   reg1_i,
    input  logic [WIDTH-1:0]   reg2_i,
    input  logic [REGADDR-1:0] wd_i,
    input  logic               wreg_i,
    output logic [WIDTH-1:0]   wdata_o,
    output logic [REGADDR-1:0] wd_o,
    output logic               wreg_o,
    output logic               ov_o,
    output logic               stallreq_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    localparam int c_shw = $clog2(WIDTH);

    logic [c_shw-1:0]   w_shamt;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rot;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_ov;
    logic               w_div_op;
    logic               w_mul_op;
    logic               w_div_ready;
    logic               w_in_rst;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    assign w_in_rst = (rst == c_rst_enable);
    assign w_shamt  = reg1_i[c_shw-1:0];
    assign w_sum    = reg1_i + reg2_i;
    assign w_diff   = reg1_i - reg2_i;
    assign w_rot    = WIDTH'({reg2_i, reg2_i} >> w_shamt);
    // Operands are pre-extended so the 2*WIDTH product is exact
    assign w_prod_s = {{WIDTH{reg1_i[WIDTH-1]}}, reg1_i} * {{WIDTH{reg2_i[WIDTH-1]}}, reg2_i};
    assign w_prod_u = {{WIDTH{1'b0}}, reg1_i} * {{WIDTH{1'b0}}, reg2_i};
    assign w_div_op = (aluop_i == c_exe_div) || (aluop_i == c_exe_divu);
    assign w_mul_op = (aluop_i == c_exe_mult) || (aluop_i == c_exe_multu);

    always_comb begin
        w_ov = 1'b0;
        if (alusel_i == c_res_arith) begin
            if (aluop_i == c_exe_add) begin
                w_ov = (reg1_i[WIDTH-1] == reg2_i[WIDTH-1]) && (w_sum[WIDTH-1] != reg1_i[WIDTH-1]);
            end else if (aluop_i == c_exe_sub) begin
                w_ov = (reg1_i[WIDTH-1] != reg2_i[WIDTH-1]) && (w_diff[WIDTH-1] != reg1_i[WIDTH-1]);
            end
        end
    end

    always_comb begin
        w_result = '0;
        case (alusel_i)
            c_res_logic: begin
                case (aluop_i)
                    c_exe_or:  w_result = reg1_i | reg2_i;
                    c_exe_and: w_result = reg1_i & reg2_i;
                    c_exe_xor: w_result = reg1_i ^ reg2_i;
                    c_exe_nor: w_result = ~(reg1_i | reg2_i);
                    default:   w_result = '0;
                endcase
            end
            c_res_shift: begin
                case (aluop_i)
                    c_exe_sll: w_result = reg2_i << w_shamt;
                    c_exe_srl: w_result = reg2_i >> w_shamt;
                    c_exe_sra: w_result = $unsigned($signed(reg2_i) >>> w_shamt);
                    c_exe_ror: w_result = w_rot;
                    default:   w_result = '0;
                endcase
            end
            c_res_arith: begin
                case (aluop_i)
                    c_exe_add, c_exe_addu: w_result = w_sum;
                    c_exe_sub, c_exe_subu: w_result = w_diff;
                    c_exe_slt:  w_result = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                    c_exe_sltu: w_result = {{(WIDTH-1){1'b0}}, (reg1_i < reg2_i)};
                    default:    w_result = '0;
                endcase
            end
            c_res_move: begin
                case (aluop_i)
                    c_exe_mfhi: w_result = r_hi;
                    c_exe_mflo: w_result = r_lo;
                    default:    w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_op && !w_in_rst),
        .signed_op (aluop_i == c_exe_div),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .abort     (flush_i),
        .ready     (w_div_ready),
        .quotient  (w_quot),
        .remainder (w_rem)
    );

    // The divide op is held while stalling, so DONE always coincides with a DIV aluop
    always_ff @(posedge clk) begin
        if (w_in_rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_ready && !flush_i) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
        end else begin
            case (aluop_i)
                c_exe_mult:  {r_hi, r_lo} <= w_prod_s;
                c_exe_multu: {r_hi, r_lo} <= w_prod_u;
                c_exe_mthi:  r_hi <= reg1_i;
                c_exe_mtlo:  r_lo <= reg1_i;
                default: ;
            endcase
        end
    end

    assign wdata_o    = w_in_rst ? '0 : w_result;
    assign wd_o       = w_in_rst ? '0 : wd_i;
    assign ov_o       = w_in_rst ? 1'b0 : w_ov;
    assign wreg_o     = (w_in_rst || w_ov || w_mul_op || w_div_op) ? c_write_disable : wreg_i;
    assign stallreq_o = !w_in_rst && w_div_op && !w_div_ready;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_md.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ex_md
// Brief    : Self-checking bench for ex_md with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_md;
    import ex_md_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [7:0]    op;
    logic [2:0]    sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    wd;
    logic          wreg;
    logic [W-1:0]  wdata_o;
    logic [4:0]    wd_o;
    logic          wreg_o;
    logic          ov_o;
    logic          stall;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    int n_vec = 0;
    int n_bad = 0;

    ex_md #(.WIDTH(W), .REGADDR(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .aluop_i(op), .alusel_i(sel),
        .reg1_i(a), .reg2_i(b), .wd_i(wd), .wreg_i(wreg),
        .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .ov_o(ov_o),
        .stallreq_o(stall), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    int           m_age = -1;

    function automatic logic is_div(input logic [7:0] o);
        return (o == c_exe_div) || (o == c_exe_divu);
    endfunction

    function automatic int div_len(input logic [W-1:0] d);
        return (d == '0) ? 2 : W + 1;
    endfunction

    function automatic logic [2:0] sel_of(input logic [7:0] o);
        case (o)
            c_exe_or, c_exe_and, c_exe_xor, c_exe_nor:                 return c_res_logic;
            c_exe_sll, c_exe_srl, c_exe_sra, c_exe_ror:                return c_res_shift;
            c_exe_add, c_exe_addu, c_exe_sub, c_exe_subu,
            c_exe_slt, c_exe_sltu:                                     return c_res_arith;
            c_exe_mfhi, c_exe_mflo, c_exe_mthi, c_exe_mtlo:            return c_res_move;
            default:                                                   return c_res_nop;
        endcase
    endfunction

    function automatic void alu_ref(input logic [7:0] o, input logic [2:0] s,
                                    input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic [W-1:0] hi, input logic [W-1:0] lo,
                                    output logic [W-1:0] res, output logic ovf);
        longint sx, sy, t;
        int     amt;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        amt = int'(x % W);
        res = '0;
        ovf = 1'b0;
        case (s)
            c_res_logic: case (o)
                c_exe_or:  res = x | y;
                c_exe_and: res = x & y;
                c_exe_xor: res = x ^ y;
                c_exe_nor: res = ~(x | y);
                default:   res = '0;
            endcase
            c_res_shift: case (o)
                c_exe_sll: res = y << amt;
                c_exe_srl: res = y >> amt;
                c_exe_sra: begin
                    res = y >> amt;
                    if (y[W-1]) res = res | ~({W{1'b1}} >> amt);
                end
                c_exe_ror: for (int i = 0; i < W; i++) res[i] = y[(i + amt) % W];
                default:   res = '0;
            endcase
            c_res_arith: case (o)
                c_exe_add: begin
                    t = sx + sy; res = x + y;
                    ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
                end
                c_exe_sub: begin
                    t = sx - sy; res = x - y;
                    ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
                end
                c_exe_addu: res = x + y;
                c_exe_subu: res = x - y;
                c_exe_slt:  res = (sx < sy) ? 1 : 0;
                c_exe_sltu: res = (x < y) ? 1 : 0;
                default:    res = '0;
            endcase
            c_res_move: case (o)
                c_exe_mfhi: res = hi;
                c_exe_mflo: res = lo;
                default:    res = '0;
            endcase
            default: res = '0;
        endcase
    endfunction

    function automatic logic [2*W-1:0] mul_ref(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          p;
        longint unsigned u;
        p = longint'($signed(x)) * longint'($signed(y));
        u = {32'b0, x} * {32'b0, y};
        return (o == c_exe_mult) ? p : u;
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [2*W-1:0] div_ref(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          q, r;
        longint unsigned uq, ur;
        logic [W-1:0]    qq, rr;
        if (y == '0) begin
            qq = '1; rr = x;
        end else if (o == c_exe_div) begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            qq = q[W-1:0]; rr = r[W-1:0];
        end else begin
            uq = {32'b0, x} / {32'b0, y};
            ur = {32'b0, x} % {32'b0, y};
            qq = uq[W-1:0]; rr = ur[W-1:0];
        end
        return {rr, qq};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= '0; m_lo <= '0; m_age <= -1;
        end else if (m_age >= 0) begin
            if (flush) begin
                m_age <= -1;
            end else if (m_age == div_len(b)) begin
                {m_hi, m_lo} <= div_ref(op, a, b);
                m_age <= -1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (is_div(op)) begin
            m_age <= 1;
        end else begin
            case (op)
                c_exe_mult, c_exe_multu: {m_hi, m_lo} <= mul_ref(op, a, b);
                c_exe_mthi: m_hi <= a;
                c_exe_mtlo: m_lo <= a;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [W-1:0] e_res;
        logic         e_ov, e_stall, e_wreg;
        logic [4:0]   e_wd;
        if (rst) begin
            e_res = '0; e_ov = 1'b0; e_stall = 1'b0; e_wreg = 1'b0; e_wd = '0;
        end else begin
            alu_ref(op, sel, a, b, m_hi, m_lo, e_res, e_ov);
            e_stall = is_div(op) && (m_age != div_len(b));
            e_wreg  = (e_ov || op == c_exe_mult || op == c_exe_multu) ? 1'b0 : wreg;
            e_wd    = wd;
        end
        if (rst || !(op == c_exe_mthi || op == c_exe_mtlo)) chk("cyc_wdata", wdata_o, e_res);
        if (rst || !is_div(op)) chk("cyc_wreg", W'(wreg_o), W'(e_wreg));
        chk("cyc_ov",    W'(ov_o),  W'(e_ov));
        chk("cyc_stall", W'(stall), W'(e_stall));
        chk("cyc_wd",    W'(wd_o),  W'(e_wd));
        chk("cyc_hi",    hi_o, m_hi);
        chk("cyc_lo",    lo_o, m_lo);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; sel = sel_of(o); a = x; b = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a divide and counts stall cycles; returns in the DONE cycle
    task automatic do_div(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int n);
        logic done;
        drive(o, x, y);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL div_timeout: got stall still high expected low after 100 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; wd = 5'd5; wreg = 1'b1;
        drive(c_exe_div, 32'd9, 32'd3);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wdata", wdata_o, '0);
        chk("rst_stall", W'(stall), '0);
        chk("rst_wreg",  W'(wreg_o), '0);
        chk("rst_wd",    W'(wd_o), '0);
        chk("rst_hi",    hi_o, '0);
        step();
        rst = 1'b0;

        drive(c_exe_sra, 32'h0000_0004, 32'hF000_00F0); #1; chk("sra", wdata_o, 32'hFF00_000F); step();
        drive(c_exe_ror, 32'h0000_0004, 32'hF000_00F0); #1; chk("ror", wdata_o, 32'h0F00_000F); step();
        drive(c_exe_sll, 32'h0000_0004, 32'hF000_00F0); #1; chk("sll", wdata_o, 32'h0000_0F00); step();
        drive(c_exe_srl, 32'h0000_0024, 32'hF000_00F0); step();
        drive(c_exe_nor, 32'h0F0F_0000, 32'h00FF_00FF); #1; chk("nor", wdata_o, 32'hF000_FF00); step();
        drive(c_exe_xor, 32'h1234_5678, 32'hFFFF_0000); step();
        drive(c_exe_and, 32'h1234_5678, 32'hFFFF_0000); step();

        drive(c_exe_add, 32'h7FFF_FFFF, 32'h1); #1;
        chk("add_res", wdata_o, 32'h8000_0000);
        chk("add_ov", W'(ov_o), 1);
        chk("add_wreg", W'(wreg_o), 0);
        step();
        drive(c_exe_addu, 32'h7FFF_FFFF, 32'h1); #1;
        chk("addu_ov", W'(ov_o), 0);
        chk("addu_wreg", W'(wreg_o), 1);
        step();
        drive(c_exe_sub, 32'h8000_0000, 32'h1); #1; chk("sub_ov", W'(ov_o), 1); step();
        drive(c_exe_slt, 32'hFFFF_FFFF, 32'h1); #1; chk("slt", wdata_o, 1); step();
        drive(c_exe_sltu, 32'hFFFF_FFFF, 32'h1); #1; chk("sltu", wdata_o, 0); step();
        drive(8'hFF, 32'h1234, 32'h5678); sel = c_res_logic; #1;
        chk("unk_wdata", wdata_o, 0);
        chk("unk_wreg", W'(wreg_o), 1);
        step();

        drive(c_exe_mult, -32'sd3, 32'd5); #1;
        chk("mult_wreg", W'(wreg_o), 0);
        chk("mult_stall", W'(stall), 0);
        step();
        drive(c_exe_mflo, 0, 0); #1;
        chk("mflo", wdata_o, 32'hFFFF_FFF1);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        step();
        drive(c_exe_multu, 32'hFFFF_FFFF, 32'h2); step();
        drive(c_exe_mthi, 32'h0000_1234, 0); step();
        drive(c_exe_mfhi, 0, 0); #1; chk("mfhi", wdata_o, 32'h0000_1234); step();

        do_div(c_exe_div, -32'sd7, 32'd2, n);
        chk("div_stall_len", n, 33);
        step(); drive(c_exe_nop, 0, 0); #1;
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);
        step();

        do_div(c_exe_divu, 32'd7, 32'd2, n);
        step(); drive(c_exe_nop, 0, 0); #1;
        chk("divu_lo", lo_o, 32'd3);
        chk("divu_hi", hi_o, 32'd1);
        step();

        do_div(c_exe_div, 32'h8000_0000, 32'hFFFF_FFFF, n);
        step(); drive(c_exe_nop, 0, 0); #1;
        chk("minneg1_lo", lo_o, 32'h8000_0000);
        chk("minneg1_hi", hi_o, 32'h0);
        step();

        // Back-to-back: second divide issued in the cycle after DONE
        do_div(c_exe_divu, 32'd7, 32'd2, n);
        chk("b2b_first_len", n, 33);
        step();
        do_div(c_exe_divu, 32'h100, 32'd0, n);
        chk("divz_stall_len", n, 2);
        step(); drive(c_exe_nop, 0, 0); #1;
        chk("divz_lo", lo_o, 32'hFFFF_FFFF);
        chk("divz_hi", hi_o, 32'h100);
        step();

        drive(c_exe_div, 32'd1000, 32'd7);
        repeat (10) step();
        flush = 1'b1; #1;
        chk("flush_pre_stall", W'(stall), 1);
        step();
        flush = 1'b0; drive(c_exe_nop, 0, 0); #1;
        chk("flush_stall", W'(stall), 0);
        chk("flush_lo", lo_o, 32'hFFFF_FFFF);
        chk("flush_hi", hi_o, 32'h100);
        step();

        drive(c_exe_divu, 32'd1000, 32'd7);
        repeat (5) step();
        rst = 1'b1; #1;
        chk("rstdiv_stall", W'(stall), 0);
        step();
        rst = 1'b0; drive(c_exe_nop, 0, 0); #1;
        chk("rstdiv_hi", hi_o, 0);
        chk("rstdiv_lo", lo_o, 0);
        step();
        do_div(c_exe_divu, 32'd1000, 32'd7, n);
        chk("post_rst_len", n, 33);
        step(); drive(c_exe_nop, 0, 0); #1;
        chk("post_rst_lo", lo_o, 32'd142);
        chk("post_rst_hi", hi_o, 32'd6);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_md.md
# ex_md

Parametrised execute stage for the Sirius pipeline, sitting between the id_ex and ex_mem registers. It covers:
- logic, shift/rotate and add/subtract/compare operations;
- a single-cycle multiplier writing the internal HI/LO pair;
- an iterative radix-2 divider that stalls the pipeline for WIDTH+1 cycles per divide.

HI/LO are architectural state owned by this block; MFHI/MFLO read them.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be ≥ 8 and a power of two.
- REGADDR, 5, register-file address width.

Ports:
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous, active-high.
- flush_i  in  1  aborts an in-flight divide; no HI/LO write.
- aluop_i  in  8  operation code; encodings come from the shared package.
- alusel_i  in  3  result class: LOGIC, SHIFT, ARITH, MOVE, NOP.
- reg1_i  in  WIDTH  operand A. For shifts, bits [log2(WIDTH)-1:0] are the shift amount.
- reg2_i  in  WIDTH  operand B; this is the value being shifted.
- wd_i  in  REGADDR  destination register.
- wreg_i  in  1  write enable for the destination register.
- wdata_o  out  WIDTH  result to ex_mem.
- wd_o  out  REGADDR  passthrough of wd_i.
- wreg_o  out  1  wreg_i, gated by overflow.
- ov_o  out  1  signed overflow on ADD/SUB.
- stallreq_o  out  1  pipeline stall request.
- hi_o, lo_o  out  WIDTH  current HI/LO register values, for debug and commit.

## Operation
Logic ops:
- OR, AND, NOR, XOR.

Shift ops (amount = reg1_i mod WIDTH):
- SLL, SRL, SRA. SRA sign-fills from reg2_i[WIDTH-1].
- ROR rotates right.

Arithmetic ops (alusel ARITH):
- ADD, SUB: modulo 2^WIDTH. ov_o=1 on signed overflow, and then wreg_o=0.
- ADDU, SUBU: never set ov_o.
- SLT / SLTU: signed / unsigned compare, result 1 or 0.

Multiply (MULT / MULTU):
- Signed / unsigned WIDTH×WIDTH product, 2·WIDTH bits.
- {HI,LO} ← product at the end of the issue cycle. wreg_o=0, no stall.

Move ops:
- MFHI / MFLO: wdata_o = HI / LO.
- MTHI / MTLO: HI / LO ← reg1_i.

Divide (DIV / DIVU):
- LO ← quotient, HI ← remainder.
- Signed divide works on magnitudes. The quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- MIN / −1 gives quotient MIN, remainder 0, no trap.
- Divide by zero gives quotient all-ones, remainder = dividend, in 2 cycles (DIVZ path).

Divider FSM states:
- IDLE:
  - a DIV op with nonzero divisor → BUSY; operands latched; counter = 0.
  - a DIV op with zero divisor → DIVZ.
- BUSY: one quotient bit per cycle; counter increments. When counter = WIDTH−1 → DONE.
- DIVZ → DONE.
- DONE: result valid; HI/LO written at the end of this cycle → IDLE.
- flush_i=1 in any non-IDLE state → IDLE at the next edge; HI/LO unchanged.

stallreq_o:
- Asserted combinationally when IDLE sees a DIV op.
- Asserted in BUSY and DIVZ.
- Deasserted in DONE.

Other rules:
- Upstream holds aluop_i and operands stable while stallreq_o=1.
- Non-DIV ops never stall.
- Unknown aluop_i: wdata_o=0, wreg_o passes through, nothing else happens.

## Timing
- Combinational outputs: wdata_o, wd_o, wreg_o, ov_o, stallreq_o.
- Registered state: HI, LO, FSM, counter, divider remainder and quotient.

Reset (rst=1 at an edge):
- HI=LO=0, FSM=IDLE, counter=0.
- While rst is high, wdata_o=0, wreg_o=0, ov_o=0, stallreq_o=0, wd_o=0.
- Reset mid-divide abandons it; HI/LO become 0.

Divide latency:
- Issue at cycle 0; BUSY for cycles 1..WIDTH; DONE at cycle WIDTH+1.
- stallreq_o is high in cycles 0..WIDTH.
- HI/LO hold the new values from cycle WIDTH+2.

Back-to-back and simultaneous events:
- A divide issued the cycle after DONE restarts from IDLE normally.
- A MULT/MTHI directly followed by MFHI reads the new value, because the HI write lands at the same edge that advances the pipeline.
- flush_i and DONE in the same cycle: flush wins, no write.

## Structure
The shared package holds:
- aluop encodings (OR … DIVU, MFHI, MFLO, MTHI, MTLO);
- alusel encodings;
- the divider FSM state enum;
- RstEnable/ZeroWord-style constants.

Sub-module div_iter (WIDTH):
- ports: clk, rst, start, signed_op, dividend, divisor, abort, ready, quotient, remainder;
- contains the FSM, the counter and the sign fix-up.

The ex_md top holds the combinational ALU, HI/LO and the result mux.

## Test plan
- Logic/shift: reg1=0x0000_0004, reg2=0xF000_00F0.
  - SRA → 0xFF00_000F; ROR → 0x0F00_000F; SLL → 0x0000_0F00.
- ADD overflow: 0x7FFF_FFFF + 1 → wdata_o=0x8000_0000, ov_o=1, wreg_o=0. ADDU of the same operands → ov_o=0, wreg_o=1.
- MULT: −3 × 5 → next cycle HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; an immediately following MFLO returns 0xFFFF_FFF1.
- DIV signed: −7 / 2 → stallreq_o high for exactly 33 cycles; then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7/2 → LO=3, HI=1.
- Boundaries: 0x8000_0000 / −1 → LO=0x8000_0000, HI=0. x / 0 → 2-cycle stall, LO=0xFFFF_FFFF, HI=x.
- Abort: flush_i at cycle 10 of a divide → stallreq_o low next cycle, HI/LO unchanged. rst at cycle 5 of a divide → HI=LO=0, FSM IDLE.
